// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: one shared edge/center-aligned counter, per-channel shadow duty compares.
// Latency: en to first period_start is one cycle; duty/mode changes apply at the next period start.
// Backpressure: none; free-running output generator, en low stops it within one cycle.
module pwm_multi_gen #(
    parameter int N_BITS = 8,
    parameter int N_CH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic [N_CH*N_BITS-1:0]   duty,
    output logic [N_CH-1:0]          pwm_out,
    output logic                     period_start,
    output logic [N_BITS-1:0]        cnt
);

    localparam logic [N_BITS-1:0] MAX = '1;
    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t            state, state_nxt;
    logic [N_BITS-1:0] cnt_q, cnt_nxt;
    logic              dir_dn, dir_dn_nxt;
    logic              mode_act;
    logic              reload;
    logic [N_BITS-1:0] duty_act [N_CH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            dir_dn   <= 1'b0;
            mode_act <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                duty_act[k] <= '0;
            end
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_nxt;
            dir_dn <= dir_dn_nxt;
            if (reload) begin
                mode_act <= mode;
                for (int k = 0; k < N_CH; k++) begin
                    duty_act[k] <= duty[k*N_BITS +: N_BITS];
                end
            end
        end
    end

    // reload fires on every edge whose successor cycle starts a new period
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        dir_dn_nxt = dir_dn;
        reload     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt    = '0;
                dir_dn_nxt = 1'b0;
                reload     = 1'b1;
                state_nxt  = en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = '0;
                    dir_dn_nxt = 1'b0;
                end else if (!mode_act) begin
                    cnt_nxt = cnt_q + ONE;
                    reload  = (cnt_q == MAX);
                end else if (!dir_dn) begin
                    if (cnt_q == MAX) begin
                        dir_dn_nxt = 1'b1;
                        cnt_nxt    = cnt_q - ONE;
                    end else begin
                        cnt_nxt = cnt_q + ONE;
                    end
                end else if (cnt_q == '0) begin
                    // only reachable defensively; the down slope reloads at cnt==1
                    dir_dn_nxt = 1'b0;
                    cnt_nxt    = cnt_q + ONE;
                end else begin
                    cnt_nxt = cnt_q - ONE;
                    reload  = (cnt_q == ONE);
                end
                if (reload) begin
                    dir_dn_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pwm_out = '0;
        for (int k = 0; k < N_CH; k++) begin
            pwm_out[k] = (state == ST_RUN) && (cnt_q < duty_act[k]);
        end
    end

    assign period_start = (state == ST_RUN) && (cnt_q == '0);
    assign cnt          = cnt_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen with N_BITS=4, N_CH=2; inputs change and outputs are sampled on the falling edge.
module tb_pwm_multi_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] duty;
    logic [1:0] pwm_out;
    logic       period_start;
    logic [3:0] cnt;

    int vectors = 0;
    int errors  = 0;
    int h0, h1, len, mx;

    pwm_multi_gen #(.N_BITS(4), .N_CH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Observe one period starting at a period_start sample; at cnt==chg_at apply new duty/mode.
    task automatic run_period(input int chg_at, input logic [7:0] nd, input logic nm,
                              output int o_h0, output int o_h1, output int o_len, output int o_mx);
        o_h0 = 0; o_h1 = 0; o_len = 0; o_mx = 0;
        do begin
            if (int'(cnt) == chg_at) begin
                duty = nd;
                mode = nm;
            end
            if (pwm_out[0] === 1'b1) o_h0++;
            if (pwm_out[1] === 1'b1) o_h1++;
            if (int'(cnt) > o_mx) o_mx = int'(cnt);
            step();
            o_len++;
        end while (period_start !== 1'b1 && o_len < 100);
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        mode = 1'b0;
        duty = 8'h5A;

        // reset holds everything low even with en high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_pwm", pwm_out, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_ps", period_start, 0);
        end
        rst = 1'b1;
        step();
        chk("rel_ps", period_start, 1);
        chk("rel_cnt", cnt, 0);
        chk("rel_pwm", pwm_out, 2'b11);

        // first period uses the duty captured at release (ch0=10, ch1=5)
        run_period(0, 8'h50, 1'b0, h0, h1, len, mx);
        chk("first_h0", h0, 10);
        chk("first_h1", h1, 5);
        chk("first_len", len, 16);

        // edge sweep: the period with ch0 shadow d is high for d cycles
        for (int d = 0; d < 16; d++) begin
            logic [3:0] nxt;
            nxt = (d == 15) ? 4'd4 : 4'(d + 1);
            run_period(0, {4'h5, nxt}, 1'b0, h0, h1, len, mx);
            chk($sformatf("sweep_h0_d%0d", d), h0, d);
            chk($sformatf("sweep_h1_d%0d", d), h1, 5);
            chk($sformatf("sweep_len_d%0d", d), len, 16);
        end

        // shadow: change to 12 at cnt==7 is invisible until the next period
        run_period(7, 8'h5C, 1'b0, h0, h1, len, mx);
        chk("shadow_cur_h0", h0, 4);
        chk("shadow_cur_h1", h1, 5);
        // mode switch requested at cnt==3: this period stays edge-aligned
        run_period(3, 8'h55, 1'b1, h0, h1, len, mx);
        chk("shadow_nxt_h0", h0, 12);
        chk("shadow_nxt_h1", h1, 5);
        chk("msw_len", len, 16);

        // center mode, duty 5 on both channels
        run_period(0, 8'h0F, 1'b1, h0, h1, len, mx);
        chk("ctr5_len", len, 30);
        chk("ctr5_h0", h0, 9);
        chk("ctr5_h1", h1, 9);
        chk("ctr5_max", mx, 15);

        // center boundaries: d=15 gives 29 cycles, d=0 none; request edge mode back
        run_period(0, 8'h5C, 1'b0, h0, h1, len, mx);
        chk("ctr15_len", len, 30);
        chk("ctr15_h0", h0, 29);
        chk("ctr0_h1", h1, 0);

        // enable drop at cnt==9 with ch0=12, ch1=5
        for (int i = 0; i < 9; i++) step();
        chk("drop_cnt_pre", cnt, 9);
        chk("drop_pwm_pre", pwm_out, 2'b01);
        en = 1'b0;
        step();
        chk("drop_pwm", pwm_out, 0);
        chk("drop_cnt", cnt, 0);
        chk("drop_ps", period_start, 0);
        duty = 8'h37;
        en   = 1'b1;
        step();
        chk("reen_ps", period_start, 1);
        chk("reen_cnt", cnt, 0);
        chk("reen_pwm", pwm_out, 2'b11);
        run_period(-1, 8'h37, 1'b0, h0, h1, len, mx);
        chk("reen_h0", h0, 7);
        chk("reen_h1", h1, 3);
        chk("reen_len", len, 16);

        // reset mid-period
        for (int i = 0; i < 5; i++) step();
        chk("mid_cnt_pre", cnt, 5);
        rst = 1'b0;
        step();
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_ps", period_start, 0);
        rst = 1'b1;
        step();
        chk("mid_rel_ps", period_start, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
